// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
// Contents: controller state enum, the hard-wired zero register address,
// and the default multiply occupancy.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1
  } state_e;

  localparam logic [4:0] ZERO_REG            = 5'd0;
  localparam int         DEFAULT_MUL_LATENCY = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with synchronous clear
// Ports:
//   Clock_i  rising-edge clock
//   Reset_i  asynchronous active-high reset, zeroes the count
//   Inc_i    add one this cycle (ignored once the count is all-ones)
//   Clr_i    zero the count on the next edge, wins over Inc_i
//   Cnt_o    current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clock_i,
  input  logic         Reset_i,
  input  logic         Inc_i,
  input  logic         Clr_i,
  output logic [W-1:0] Cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Clr_i) begin
      cnt_d = '0;
    end else if (Inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign Cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/bubble/flush sequencing for the 5-stage pipeline
// Ports:
//   Clock_i, Reset_i            clock, asynchronous active-high reset
//   RsAddrD_i, RtAddrD_i        source registers of the DEC instruction
//   UsesRsD_i, UsesRtD_i        DEC instruction actually reads Rs / Rt
//   MemReadE_i, RAddrE_i        EX instruction is a load, and its destination
//   MULOpE_i                    EX instruction is a multi-cycle multiply
//   BranchTakenE_i              branch/jump in EX resolved taken
//   ClearCnt_i                  clear both performance counters
//   StallF_o/StallD_o/StallE_o  hold PC, IF/DEC, DEC/EX
//   FlushD_o                    clear IF/DEC to NOP
//   BubbleE_o/BubbleM_o         load NOP into DEC/EX, EX/MEM
//   MulBusy_o                   multiply wait in progress
//   StallCnt_o/FlushCnt_o       saturating stall-cycle and flush-event counts
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
  parameter int CNT_W       = 16
) (
  input  logic             Clock_i,
  input  logic             Reset_i,
  input  logic [4:0]       RsAddrD_i,
  input  logic [4:0]       RtAddrD_i,
  input  logic             UsesRsD_i,
  input  logic             UsesRtD_i,
  input  logic             MemReadE_i,
  input  logic [4:0]       RAddrE_i,
  input  logic             MULOpE_i,
  input  logic             BranchTakenE_i,
  input  logic             ClearCnt_i,
  output logic             StallF_o,
  output logic             StallD_o,
  output logic             StallE_o,
  output logic             FlushD_o,
  output logic             BubbleE_o,
  output logic             BubbleM_o,
  output logic             MulBusy_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o
);

  localparam int            MCW       = $clog2(MUL_LATENCY + 1);
  localparam bit            MUL_MULTI = (MUL_LATENCY > 1);
  localparam logic [MCW-1:0] CNT_ONE  = MCW'(1);
  localparam logic [MCW-1:0] CNT_LOAD = MCW'(MUL_LATENCY - 1);

  state_e         state_q, state_d;
  logic [MCW-1:0] mul_cnt_q, mul_cnt_d;

  logic mul_stall, flush, load_use, rs_hit, rt_hit;

  always_comb begin
    // The multiply stalls from its first EX cycle; the final cycle in
    // MUL_WAIT (count reaches 1) lets the result advance to EX/MEM.
    mul_stall = ((state_q == RUN) && MULOpE_i && MUL_MULTI) ||
                ((state_q == MUL_WAIT) && (mul_cnt_q != CNT_ONE));
    flush     = BranchTakenE_i && !mul_stall;
    rs_hit    = UsesRsD_i && (RsAddrD_i == RAddrE_i);
    rt_hit    = UsesRtD_i && (RtAddrD_i == RAddrE_i);
    // The bubble inserted here moves the load to MEM next cycle, so a pair
    // only ever stalls once. A taken branch kills the dependent anyway.
    load_use  = MemReadE_i && (RAddrE_i != ZERO_REG) && (rs_hit || rt_hit) &&
                !mul_stall && !BranchTakenE_i;
  end

  // Controls are forced low while reset is held so an aborted multiply
  // releases the pipeline without waiting for a clock edge.
  assign StallF_o  = !Reset_i && (mul_stall || load_use);
  assign StallD_o  = !Reset_i && (mul_stall || load_use);
  assign StallE_o  = !Reset_i && mul_stall;
  assign BubbleM_o = !Reset_i && mul_stall;
  assign FlushD_o  = !Reset_i && flush;
  assign BubbleE_o = !Reset_i && (flush || load_use);
  assign MulBusy_o = (state_q == MUL_WAIT);

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      RUN: begin
        if (MULOpE_i && MUL_MULTI) begin
          state_d   = MUL_WAIT;
          mul_cnt_d = CNT_LOAD;
        end
      end
      MUL_WAIT: begin
        // MULOpE is ignored here: it is the same instruction still in EX.
        mul_cnt_d = mul_cnt_q - CNT_ONE;
        if (mul_cnt_q == CNT_ONE) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = RUN;
        mul_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q   <= RUN;
      mul_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clock_i (Clock_i),
    .Reset_i (Reset_i),
    .Inc_i   (StallF_o),
    .Clr_i   (ClearCnt_i),
    .Cnt_o   (StallCnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clock_i (Clock_i),
    .Reset_i (Reset_i),
    .Inc_i   (FlushD_o),
    .Clr_i   (ClearCnt_i),
    .Cnt_o   (FlushCnt_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int LAT     = 4;
  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             sf, sd, se, fd, be, bm, busy;
    logic [CNT_W-1:0] sc, fc;
  } obs_t;

  logic             Clock = 1'b0;
  logic             Reset = 1'b1;
  logic [4:0]       RsAddrD = '0, RtAddrD = '0, RAddrE = '0;
  logic             UsesRsD = 1'b0, UsesRtD = 1'b0, MemReadE = 1'b0;
  logic             MULOpE = 1'b0, BranchTakenE = 1'b0, ClearCnt = 1'b0;
  logic             StallF, StallD, StallE, FlushD, BubbleE, BubbleM, MulBusy;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  hazard_ctrl #(.MUL_LATENCY(LAT), .CNT_W(CNT_W)) u_dut (
    .Clock_i        (Clock),
    .Reset_i        (Reset),
    .RsAddrD_i      (RsAddrD),
    .RtAddrD_i      (RtAddrD),
    .UsesRsD_i      (UsesRsD),
    .UsesRtD_i      (UsesRtD),
    .MemReadE_i     (MemReadE),
    .RAddrE_i       (RAddrE),
    .MULOpE_i       (MULOpE),
    .BranchTakenE_i (BranchTakenE),
    .ClearCnt_i     (ClearCnt),
    .StallF_o       (StallF),
    .StallD_o       (StallD),
    .StallE_o       (StallE),
    .FlushD_o       (FlushD),
    .BubbleE_o      (BubbleE),
    .BubbleM_o      (BubbleM),
    .MulBusy_o      (MulBusy),
    .StallCnt_o     (StallCnt),
    .FlushCnt_o     (FlushCnt)
  );

  always #5 Clock = ~Clock;

  obs_t exp_q[$];
  int   id_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_issued = 0;

  // Reference model: mul_age is how many cycles the current multiply has
  // already spent in EX (-1 when none); a multiply stalls on cycles
  // 0..LAT-2 of its EX residency and reads busy from cycle 1 onwards.
  int m_age = -1;
  int m_sc  = 0;
  int m_fc  = 0;

  task automatic apply(input bit rst, input bit mulop, input bit br,
                       input bit mr, input logic [4:0] ra,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit clr);
    obs_t e;
    int   k;
    bit   mul, lu, fl, st;
    @(posedge Clock);
    #1;
    Reset = rst; MULOpE = mulop; BranchTakenE = br; MemReadE = mr;
    RAddrE = ra; RsAddrD = rs; RtAddrD = rt; UsesRsD = urs; UsesRtD = urt;
    ClearCnt = clr;
    e = '0;
    if (rst) begin
      m_age = -1; m_sc = 0; m_fc = 0;
    end else begin
      k   = (m_age >= 0) ? m_age : ((mulop && LAT > 1) ? 0 : -1);
      mul = (k >= 0) && (k < LAT - 1);
      fl  = br && !mul;
      lu  = !mul && !br && mr && (ra != 5'd0) &&
            ((urs && rs == ra) || (urt && rt == ra));
      st  = mul || lu;
      e.sf = st; e.sd = st; e.se = mul; e.bm = mul;
      e.fd = fl; e.be = fl || lu;
      e.busy = (k >= 1);
      e.sc = CNT_W'(m_sc); e.fc = CNT_W'(m_fc);
      m_age = mul ? k + 1 : -1;
      if (clr) begin
        m_sc = 0; m_fc = 0;
      end else begin
        if (st && m_sc < CNT_MAX) m_sc++;
        if (fl && m_fc < CNT_MAX) m_fc++;
      end
    end
    exp_q.push_back(e);
    id_q.push_back(n_issued);
    n_issued++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  always @(negedge Clock) begin
    obs_t e, a;
    int   id;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = '{sf: StallF, sd: StallD, se: StallE, fd: FlushD, be: BubbleE,
             bm: BubbleM, busy: MulBusy, sc: StallCnt, fc: FlushCnt};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL vec%0d: got sf,sd,se,fd,be,bm,busy=%b stall=%0d flush=%0d, expected %b stall=%0d flush=%0d",
                 id, a[2*CNT_W+6 -: 7], a.sc, a.fc, e[2*CNT_W+6 -: 7], e.sc, e.fc);
      end
    end
  end

  initial begin
    // reset state
    apply(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    apply(1, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 0);
    idle(2);
    // load-use on Rs, then on Rt
    apply(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
    idle(1);
    apply(0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1, 0);
    // unused operand does not stall
    apply(0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 0, 1, 0);
    // load to R0 never stalls
    apply(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0);
    idle(1);
    // multiply held in EX, then back-to-back multiplies
    for (int i = 0; i < LAT; i++) apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    for (int i = 0; i < LAT; i++) apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(2);
    // branch with a coincident load-use match
    apply(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0);
    idle(1);
    // reset mid-multiply (third EX cycle, count at 2)
    apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    apply(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(2);
    // flush counter saturation, hold, and clear beating a flush
    for (int i = 0; i < CNT_MAX + 3; i++) apply(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    apply(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
    apply(0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    idle(1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 199) == 0));
    end
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge Clock);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
